// File: rtl/ring_decoder.sv
// ring_decoder: position decoder and integrity monitor for a one-hot ring.
// Converts each valid one-hot sample to a binary index, flags words that are
// not exactly one-hot, flags legal words that are not the next rotation, and
// counts completed revolutions (saturating).
// Build option: define RING_DEC_RESYNC_EN to relock on the offending sample
// after a rotation mismatch; otherwise a mismatch parks the FSM in FAULT.
module ring_decoder #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  input  logic             clr,
  output logic [IDXW-1:0]  idx_out,
  output logic             idx_vld,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             locked,
  output logic [WRAPW-1:0] wrap_cnt
);

  typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_t;

  state_t           state, state_next;
  logic [IDXW-1:0]  prev_idx, prev_next;
  logic [IDXW-1:0]  idx_next, sample_idx, expected_idx;
  logic [WRAPW-1:0] wrap_next;
  logic             ivld_next, oerr_next, serr_next;
  logic             legal;

  function automatic logic [WRAPW-1:0] sat_inc(input logic [WRAPW-1:0] v);
    return (&v) ? v : v + WRAPW'(1);
  endfunction

  function automatic logic [IDXW-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = IDXW'(i);
    return idx;
  endfunction

  function automatic logic [IDXW-1:0] successor(input logic [IDXW-1:0] p);
    return (p == IDXW'(WIDTH - 1)) ? '0 : p + IDXW'(1);
  endfunction

  assign legal        = ring_vld && ($countones(ring_in) == 1);
  assign sample_idx   = onehot_to_idx(ring_in);
  assign expected_idx = successor(prev_idx);

  // Next-state, next-output and counter logic for one sample per cycle.
  always_comb begin
    state_next = state;
    prev_next  = prev_idx;
    idx_next   = idx_out;
    wrap_next  = wrap_cnt;
    ivld_next  = 1'b0;
    oerr_next  = 1'b0;
    serr_next  = 1'b0;
    if (clr) begin
      state_next = SEARCH;
      idx_next   = '0;
      wrap_next  = '0;
    end else if (ring_vld) begin
      if (!legal) begin
        oerr_next = 1'b1;
        if (state == LOCKED) state_next = SEARCH;
      end else begin
        idx_next  = sample_idx;
        ivld_next = 1'b1;
        prev_next = sample_idx;
        case (state)
          SEARCH: state_next = LOCKED;
          LOCKED: begin
            if (sample_idx == expected_idx) begin
              // Only the last-to-first step closes a revolution.
              if (sample_idx == '0) wrap_next = sat_inc(wrap_cnt);
            end else begin
              serr_next = 1'b1;
`ifdef RING_DEC_RESYNC_EN
              // Pass through SEARCH and relock on this very sample.
              state_next = LOCKED;
`else
              state_next = FAULT;
`endif
            end
          end
          default: state_next = state;
        endcase
      end
    end
  end

  // Control state and registered outputs; reset is asynchronous active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      idx_out    <= '0;
      idx_vld    <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_next;
      idx_out    <= idx_next;
      idx_vld    <= ivld_next;
      onehot_err <= oerr_next;
      seq_err    <= serr_next;
      locked     <= (state_next == LOCKED);
      wrap_cnt   <= wrap_next;
    end
  end

  // Reference position for the rotation check; only read once locked.
  always_ff @(posedge clk) begin
    prev_idx <= prev_next;
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder (WIDTH=4, WRAPW=2) with a behavioural
// reference model; follows RING_DEC_RESYNC_EN if defined for the build.
module tb_ring_decoder;
  localparam int WIDTH = 4;
  localparam int IDXW  = 2;
  localparam int WRAPW = 2;
  localparam int M_SEARCH = 0, M_LOCKED = 1, M_FAULT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ring_in;
  logic             ring_vld;
  logic             clr;
  logic [IDXW-1:0]  idx_out;
  logic             idx_vld, onehot_err, seq_err, locked;
  logic [WRAPW-1:0] wrap_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_mode, m_prev, m_idx, m_wrap;
  logic e_ivld, e_oerr, e_serr;

  ring_decoder #(.WIDTH(WIDTH), .IDXW(IDXW), .WRAPW(WRAPW)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld), .clr(clr),
    .idx_out(idx_out), .idx_vld(idx_vld), .onehot_err(onehot_err),
    .seq_err(seq_err), .locked(locked), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] got();
    return {idx_out, idx_vld, onehot_err, seq_err, locked, wrap_cnt};
  endfunction

  function automatic logic [7:0] want();
    return {IDXW'(m_idx), e_ivld, e_oerr, e_serr, (m_mode == M_LOCKED), WRAPW'(m_wrap)};
  endfunction

  function automatic int position(input logic [WIDTH-1:0] r);
    int p;
    p = 0;
    for (int i = 0; i < WIDTH; i++) if (r[i]) p = i;
    return p;
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_idx = 0; m_wrap = 0; m_prev = 0;
    e_ivld = 0; e_oerr = 0; e_serr = 0;
  endtask

  // Drive one cycle, advance the model at the edge, return 1 ns after it.
  task automatic drive(input logic [WIDTH-1:0] r, input logic v, input logic c);
    int p;
    @(negedge clk);
    ring_in = r; ring_vld = v; clr = c;
    @(posedge clk);
    e_ivld = 0; e_oerr = 0; e_serr = 0;
    if (c) begin
      m_mode = M_SEARCH; m_idx = 0; m_wrap = 0;
    end else if (v) begin
      if ($countones(r) != 1) begin
        e_oerr = 1;
        if (m_mode == M_LOCKED) m_mode = M_SEARCH;
      end else begin
        p = position(r);
        m_idx = p; e_ivld = 1;
        if (m_mode == M_SEARCH) m_mode = M_LOCKED;
        else if (m_mode == M_LOCKED) begin
          if (p == (m_prev + 1) % WIDTH) begin
            if (p == 0 && m_wrap < (1 << WRAPW) - 1) m_wrap = m_wrap + 1;
          end else begin
            e_serr = 1;
`ifdef RING_DEC_RESYNC_EN
            m_mode = M_LOCKED;
`else
            m_mode = M_FAULT;
`endif
          end
        end
        m_prev = p;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    ring_in = '0; ring_vld = 0; clr = 0; rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (got() !== 8'h00) begin
      n_err++; $display("FAIL reset_state got=%h want=00", got());
    end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_basic_sequence();
    logic [WIDTH-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1, 0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL basic_step%0d got=%h want=%h", i, got(), want());
      end
    end
    n_vec++;
    if (wrap_cnt !== 2'd1 || idx_out !== 2'd0 || locked !== 1'b1) begin
      n_err++; $display("FAIL basic_final wrap=%0d idx=%0d locked=%b want 1,0,1", wrap_cnt, idx_out, locked);
    end
  endtask

  task automatic test_onehot_err();
    logic [WIDTH-1:0] seq [4] = '{4'b0001, 4'b0010, 4'b0110, 4'b0000};
    drive('0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1, 0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL onehot_step%0d got=%h want=%h", i, got(), want());
      end
      if (i >= 2) begin
        n_vec++;
        if (onehot_err !== 1'b1 || seq_err !== 1'b0 || idx_out !== 2'd1 || locked !== 1'b0) begin
          n_err++; $display("FAIL onehot_pulse%0d oerr=%b serr=%b idx=%0d locked=%b want 1,0,1,0", i, onehot_err, seq_err, idx_out, locked);
        end
      end
    end
  endtask

  task automatic test_seq_err();
    drive('0, 0, 1);
    drive(4'b0001, 1, 0);
    drive(4'b0010, 1, 0);
    drive(4'b1000, 1, 0);
    n_vec++;
    if (got() !== want() || seq_err !== 1'b1) begin
      n_err++; $display("FAIL seq_err_pulse got=%h want=%h", got(), want());
    end
    drive(4'b0001, 1, 0);
    n_vec++;
    if (got() !== want()) begin
      n_err++; $display("FAIL seq_err_after got=%h want=%h", got(), want());
    end
`ifdef RING_DEC_RESYNC_EN
    n_vec++;
    if (locked !== 1'b1 || wrap_cnt !== 2'd1 || seq_err !== 1'b0) begin
      n_err++; $display("FAIL resync locked=%b wrap=%0d serr=%b want 1,1,0", locked, wrap_cnt, seq_err);
    end
`else
    drive(4'b0010, 1, 0);
    drive(4'b0001, 1, 0);
    n_vec++;
    if (locked !== 1'b0 || wrap_cnt !== 2'd0 || seq_err !== 1'b0 || idx_out !== 2'd0) begin
      n_err++; $display("FAIL fault_sticky locked=%b wrap=%0d serr=%b idx=%0d want 0,0,0,0", locked, wrap_cnt, seq_err, idx_out);
    end
    drive('0, 0, 1);
    drive(4'b0100, 1, 0);
    n_vec++;
    if (locked !== 1'b1 || got() !== want()) begin
      n_err++; $display("FAIL fault_clr got=%h want=%h", got(), want());
    end
`endif
  endtask

  task automatic test_saturation();
    logic [WRAPW-1:0] exp_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive('0, 0, 1);
    drive(4'b0001, 1, 0);
    for (int r = 0; r < 5; r++) begin
      for (int k = 1; k <= WIDTH; k++) drive(WIDTH'(1 << (k % WIDTH)), 1, 0);
      n_vec++;
      if (wrap_cnt !== exp_wrap[r] || got() !== want()) begin
        n_err++; $display("FAIL saturate_rev%0d wrap=%0d want=%0d", r, wrap_cnt, exp_wrap[r]);
      end
    end
  endtask

  task automatic test_gap();
    drive('0, 0, 1);
    drive(4'b0001, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(WIDTH'($urandom), 0, 0);
      n_vec++;
      if (got() !== want() || idx_vld !== 1'b0) begin
        n_err++; $display("FAIL gap_idle%0d got=%h want=%h", i, got(), want());
      end
    end
    drive(4'b0010, 1, 0);
    n_vec++;
    if (seq_err !== 1'b0 || idx_out !== 2'd1 || locked !== 1'b1 || idx_vld !== 1'b1) begin
      n_err++; $display("FAIL gap_resume serr=%b idx=%0d locked=%b vld=%b want 0,1,1,1", seq_err, idx_out, locked, idx_vld);
    end
  endtask

  task automatic test_reset_mid();
    drive('0, 0, 1);
    drive(4'b0001, 1, 0);
    drive(4'b0010, 1, 0);
    drive(4'b0001, 1, 0);
    drive(4'b0010, 1, 0);
    drive(4'b0100, 1, 0);
    #2 rst = 0;
    #1;
    n_vec++;
    if (got() !== 8'h00) begin
      n_err++; $display("FAIL reset_async got=%h want=00", got());
    end
    model_reset();
    @(negedge clk); rst = 1;
    drive(4'b0100, 1, 1);
    n_vec++;
    if (got() !== 8'h00) begin
      n_err++; $display("FAIL clr_priority got=%h want=00", got());
    end
    drive(4'b0100, 1, 0);
    n_vec++;
    if (got() !== want() || seq_err !== 1'b0 || locked !== 1'b1) begin
      n_err++; $display("FAIL relock got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_random();
    int cur, sel;
    logic [WIDTH-1:0] r;
    logic v, c;
    drive('0, 0, 1);
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      v = 1; c = ($urandom_range(0, 99) < 2);
      if (sel < 70) begin
        cur = (cur + 1) % WIDTH; r = WIDTH'(1 << cur);
      end else if (sel < 80) begin
        cur = $urandom_range(0, WIDTH - 1); r = WIDTH'(1 << cur);
      end else if (sel < 90) begin
        r = WIDTH'($urandom);
      end else begin
        r = WIDTH'($urandom); v = 0;
      end
      drive(r, v, c);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL random%0d in=%b vld=%b clr=%b got=%h want=%h", i, r, v, c, got(), want());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_onehot_err();
    test_seq_err();
    test_saturation();
    test_gap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
